// File: rtl/rtc_bus_transaction_ctrl.sv
// RTC multiplexed address/data bus transaction controller.
// Runs one complete read or write cycle on the external RTC chip for each
// request from the RTC sequencer. The timing of CS, AD, WR, RD and the pad
// output enable comes from a per-state cycle counter.
//
// Handshake with the sequencer: the controller samples in_en_funcion_rtc
// only while IDLE. In that same cycle it latches direction, address and write
// data. It then ignores every request input until it raises out_flag_done
// for exactly one cycle, in the DONE state. IDLE always lasts at least one
// cycle, so the sequencer has one edge to present the next address before
// that address is sampled.
module rtc_bus_transaction_ctrl #(
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 8,
   parameter int T_HOLD  = 2,
   parameter int T_REC   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_en_funcion_rtc,
   input  logic       in_funcion_w_r,
   input  logic [7:0] in_addr_ram_rtc,
   input  logic       in_flag_inicio,
   input  logic [7:0] in_dato_inicio,
   input  logic [7:0] in_dato_config,
   input  logic [7:0] in_bus_dato,
   output logic [7:0] out_bus_dato,
   output logic       out_bus_oe,
   output logic       out_bus_cs_n,
   output logic       out_bus_ad,
   output logic       out_bus_wr_n,
   output logic       out_bus_rd_n,
   output logic       out_flag_done,
   output logic [7:0] out_dato_leido,
   output logic [7:0] out_addr_leido,
   output logic       out_dato_valido,
   output logic       out_ocupado
);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_ADDR_SETUP = 4'd1,
      S_ADDR_PULSE = 4'd2,
      S_ADDR_HOLD  = 4'd3,
      S_DATA_SETUP = 4'd4,
      S_DATA_PULSE = 4'd5,
      S_DATA_HOLD  = 4'd6,
      S_RECOVER    = 4'd7,
      S_DONE       = 4'd8
   } state_t;

   // Final counter value of each timed state.
   localparam logic [7:0] SETUP_LAST = 8'(T_SETUP - 1);
   localparam logic [7:0] PULSE_LAST = 8'(T_PULSE - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(T_HOLD - 1);
   localparam logic [7:0] REC_LAST   = 8'(T_REC - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       w_r_q, w_r_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;
   logic [7:0] dato_leido_q, dato_leido_d;
   logic [7:0] addr_leido_q, addr_leido_d;
   logic [7:0] cnt_last;
   logic       state_end;

   // Final counter value of the current state. DONE lasts one cycle and IDLE
   // has no length of its own.
   always_comb begin
      cnt_last = 8'd0;
      case (state_q)
         S_ADDR_SETUP, S_DATA_SETUP: cnt_last = SETUP_LAST;
         S_ADDR_PULSE, S_DATA_PULSE: cnt_last = PULSE_LAST;
         S_ADDR_HOLD,  S_DATA_HOLD:  cnt_last = HOLD_LAST;
         S_RECOVER:                  cnt_last = REC_LAST;
         default:                    cnt_last = 8'd0;
      endcase
   end

   assign state_end = (cnt_q == cnt_last);

   // Next state, cycle counter and the transaction/read-back latches.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + 8'd1;
      w_r_d        = w_r_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      dato_leido_d = dato_leido_q;
      addr_leido_d = addr_leido_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 8'd0;
            if (in_en_funcion_rtc) begin
               state_d = S_ADDR_SETUP;
               w_r_d   = in_funcion_w_r;
               addr_d  = in_addr_ram_rtc;
               wdata_d = in_flag_inicio ? in_dato_inicio : in_dato_config;
            end
         end
         S_ADDR_SETUP: if (state_end) state_d = S_ADDR_PULSE;
         S_ADDR_PULSE: if (state_end) state_d = S_ADDR_HOLD;
         S_ADDR_HOLD:  if (state_end) state_d = S_DATA_SETUP;
         S_DATA_SETUP: if (state_end) state_d = S_DATA_PULSE;
         S_DATA_PULSE: begin
            if (state_end) begin
               state_d = S_DATA_HOLD;
               // Capture the pad while RD is still asserted.
               if (!w_r_q) rdata_d = in_bus_dato;
            end
         end
         S_DATA_HOLD:  if (state_end) state_d = S_RECOVER;
         S_RECOVER: begin
            if (state_end) begin
               state_d = S_DONE;
               // Publish the read result so it is visible during DONE,
               // in the same cycle as the valid pulse.
               if (!w_r_q) begin
                  dato_leido_d = rdata_q;
                  addr_leido_d = addr_q;
               end
            end
         end
         S_DONE:       state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
      if (state_d != state_q) cnt_d = 8'd0;
   end

   // State and datapath registers; reset aborts any transaction immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 8'd0;
         w_r_q        <= 1'b0;
         addr_q       <= 8'h00;
         wdata_q      <= 8'h00;
         rdata_q      <= 8'h00;
         dato_leido_q <= 8'h00;
         addr_leido_q <= 8'h00;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         w_r_q        <= w_r_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         dato_leido_q <= dato_leido_d;
         addr_leido_q <= addr_leido_d;
      end
   end

   // Bus controls decoded from the state register and the latched request only.
   always_comb begin
      out_bus_cs_n    = 1'b1;
      out_bus_ad      = 1'b1;
      out_bus_wr_n    = 1'b1;
      out_bus_rd_n    = 1'b1;
      out_bus_oe      = 1'b0;
      out_bus_dato    = 8'h00;
      out_flag_done   = 1'b0;
      out_dato_valido = 1'b0;
      case (state_q)
         S_ADDR_SETUP, S_ADDR_PULSE, S_ADDR_HOLD: begin
            out_bus_cs_n = 1'b0;
            out_bus_oe   = 1'b1;
            out_bus_dato = addr_q;
            if (state_q == S_ADDR_PULSE) out_bus_wr_n = 1'b0;
         end
         S_DATA_SETUP, S_DATA_PULSE, S_DATA_HOLD: begin
            out_bus_cs_n = 1'b0;
            out_bus_ad   = 1'b0;
            if (w_r_q) begin
               out_bus_oe   = 1'b1;
               out_bus_dato = wdata_q;
            end
            if (state_q == S_DATA_PULSE) begin
               out_bus_wr_n = ~w_r_q;
               out_bus_rd_n = w_r_q;
            end
         end
         S_DONE: begin
            out_flag_done   = 1'b1;
            out_dato_valido = ~w_r_q;
         end
         default: ;
      endcase
   end

   assign out_ocupado    = (state_q != S_IDLE);
   assign out_dato_leido = dato_leido_q;
   assign out_addr_leido = addr_leido_q;

endmodule

// File: tb/tb_rtc_bus_transaction_ctrl.sv
// Bench for rtc_bus_transaction_ctrl. The reference model tracks each
// transaction as a cycle offset k from the request (k=0 means idle). Every
// expected pin value comes from which timing window k falls in.
module tb_rtc_bus_transaction_ctrl;

  localparam int TS = 2, TP = 8, TH = 2, TR = 4;
  localparam int L      = TS + TP + TH;     // one bus phase
  localparam int DONE_K = 2 * L + TR + 1;   // 29
  localparam int CAP_K  = L + TS + TP;      // last data-pulse cycle

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       in_en_funcion_rtc = 1'b0;
  logic       in_funcion_w_r = 1'b0;
  logic [7:0] in_addr_ram_rtc = 8'h00;
  logic       in_flag_inicio = 1'b0;
  logic [7:0] in_dato_inicio = 8'h00;
  logic [7:0] in_dato_config = 8'h00;
  logic [7:0] in_bus_dato = 8'h00;
  logic [7:0] out_bus_dato, out_dato_leido, out_addr_leido;
  logic       out_bus_oe, out_bus_cs_n, out_bus_ad, out_bus_wr_n, out_bus_rd_n;
  logic       out_flag_done, out_dato_valido, out_ocupado;

  rtc_bus_transaction_ctrl #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_REC(TR)) dut (
    .clk(clk), .reset(reset),
    .in_en_funcion_rtc(in_en_funcion_rtc), .in_funcion_w_r(in_funcion_w_r),
    .in_addr_ram_rtc(in_addr_ram_rtc), .in_flag_inicio(in_flag_inicio),
    .in_dato_inicio(in_dato_inicio), .in_dato_config(in_dato_config),
    .in_bus_dato(in_bus_dato), .out_bus_dato(out_bus_dato), .out_bus_oe(out_bus_oe),
    .out_bus_cs_n(out_bus_cs_n), .out_bus_ad(out_bus_ad), .out_bus_wr_n(out_bus_wr_n),
    .out_bus_rd_n(out_bus_rd_n), .out_flag_done(out_flag_done),
    .out_dato_leido(out_dato_leido), .out_addr_leido(out_addr_leido),
    .out_dato_valido(out_dato_valido), .out_ocupado(out_ocupado)
  );

  // ---------------- scoreboard state ----------------
  int n_vectors = 0;
  int n_miscompares = 0;
  int cyc = 0;
  int k = 0;
  logic       m_wr = 1'b0;
  logic [7:0] m_addr = 8'h00, m_data = 8'h00, m_cap = 8'h00;
  logic [7:0] m_dleido = 8'h00, m_aleido = 8'h00;
  logic [7:0] pad_val = 8'h00;
  bit   scramble = 1'b0, seq_mode = 1'b0;
  int   req_cyc = 0, done_cyc = 0, cs_fall_cyc = 0;
  logic prev_cs = 1'b1;
  logic [7:0] exp_q[$];   // expected read data, pushed on each read request

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s cyc=%0d k=%0d got=0x%02h exp=0x%02h", tag, cyc, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_dleido = 8'h00;
    m_aleido = 8'h00;
  endtask

  // Compare every output against the window that k falls in.
  task automatic check_outputs();
    bit in_tx, addr_ph, data_ph, a_pul, d_pul, done;
    in_tx   = (k >= 1 && k <= 2 * L);
    addr_ph = (k >= 1 && k <= L);
    data_ph = (k > L && k <= 2 * L);
    a_pul   = (k > TS && k <= TS + TP);
    d_pul   = (k > L + TS && k <= L + TS + TP);
    done    = (k == DONE_K);
    check_eq("cs_n", 8'(out_bus_cs_n), 8'(!in_tx));
    check_eq("ad", 8'(out_bus_ad), 8'(!data_ph));
    check_eq("wr_n", 8'(out_bus_wr_n), 8'(!(a_pul || (m_wr && d_pul))));
    check_eq("rd_n", 8'(out_bus_rd_n), 8'(!(!m_wr && d_pul)));
    check_eq("oe", 8'(out_bus_oe), 8'(addr_ph || (m_wr && data_ph)));
    check_eq("bus", out_bus_dato, addr_ph ? m_addr : ((m_wr && data_ph) ? m_data : 8'h00));
    check_eq("done", 8'(out_flag_done), 8'(done));
    check_eq("valid", 8'(out_dato_valido), 8'(done && !m_wr));
    check_eq("busy", 8'(out_ocupado), 8'(k != 0));
    check_eq("dato_leido", out_dato_leido, m_dleido);
    check_eq("addr_leido", out_addr_leido, m_aleido);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    int prev_k;
    @(negedge clk);
    check_outputs();
    if (out_flag_done) done_cyc = cyc;
    if (prev_cs && !out_bus_cs_n) cs_fall_cyc = cyc;
    prev_cs = out_bus_cs_n;
    @(posedge clk);
    prev_k = k;
    if (!reset) begin
      model_reset();
    end else if (k == 0) begin
      if (in_en_funcion_rtc) begin
        m_wr    = in_funcion_w_r;
        m_addr  = in_addr_ram_rtc;
        m_data  = in_flag_inicio ? in_dato_inicio : in_dato_config;
        req_cyc = cyc;
        k = 1;
      end
    end else begin
      if (k == CAP_K && !m_wr) m_cap = in_bus_dato;
      if (k == DONE_K - 1 && !m_wr) begin
        m_dleido = m_cap;
        m_aleido = m_addr;
      end
      k = (k == DONE_K) ? 0 : k + 1;
    end
    cyc++;
    #1;
    in_bus_dato = (k == CAP_K) ? pad_val : 8'($urandom);
    if (seq_mode && prev_k == DONE_K) in_addr_ram_rtc = in_addr_ram_rtc + 8'd1;
    if (scramble && k != 0) begin
      in_funcion_w_r  = 1'($urandom);
      in_addr_ram_rtc = 8'($urandom);
      in_flag_inicio  = 1'($urandom);
      in_dato_inicio  = 8'($urandom);
      in_dato_config  = 8'($urandom);
    end
  endtask

  task automatic run_until_idle();
    int n = 0;
    while (k != 0 && n < 100) begin
      tick();
      if (k == DONE_K) in_en_funcion_rtc = 1'b0;
      n++;
    end
    check_eq("idle_timeout", 8'(k != 0), 8'd0);
  endtask

  task automatic do_txn(input logic wr, input logic [7:0] addr, input logic flag,
                        input logic [7:0] d_ini, input logic [7:0] d_cfg);
    in_funcion_w_r = wr;
    in_addr_ram_rtc = addr;
    in_flag_inicio = flag;
    in_dato_inicio = d_ini;
    in_dato_config = d_cfg;
    in_en_funcion_rtc = 1'b1;
    if (!wr) exp_q.push_back(pad_val);
    tick();
    in_en_funcion_rtc = 1'b0;
    run_until_idle();
    check_eq("latency", 8'(done_cyc - req_cyc), 8'(DONE_K));
    if (!wr) check_eq("rd_result", out_dato_leido, exp_q.pop_front());
  endtask

  initial begin
    int gap;
    // reset held: outputs at reset values
    repeat (3) tick();
    reset = 1'b1;
    repeat (50) tick();

    // directed write from config data
    pad_val = 8'h00;
    do_txn(1'b1, 8'h21, 1'b0, 8'h99, 8'h45);
    // write from init data
    do_txn(1'b1, 8'h10, 1'b1, 8'hD2, 8'h00);
    // read, pad carries 0x5A only on the last data-pulse cycle
    pad_val = 8'h5A;
    do_txn(1'b0, 8'hF0, 1'b0, 8'h00, 8'h00);
    check_eq("addr_leido_F0", out_addr_leido, 8'hF0);

    // en held high, sequencer increments address on done
    seq_mode = 1'b1;
    in_funcion_w_r = 1'b1;
    in_addr_ram_rtc = 8'h21;
    in_flag_inicio = 1'b0;
    in_dato_config = 8'h33;
    in_en_funcion_rtc = 1'b1;
    for (int i = 0; i < 2 * (DONE_K + 1) - 1; i++) tick();
    check_eq("b2b_gap", 8'(cs_fall_cyc - done_cyc), 8'd2);
    check_eq("b2b_addr", m_addr, 8'h22);
    in_en_funcion_rtc = 1'b0;
    seq_mode = 1'b0;
    run_until_idle();

    // reset in the data pulse of a write
    in_funcion_w_r = 1'b1;
    in_addr_ram_rtc = 8'h44;
    in_dato_config = 8'h77;
    in_en_funcion_rtc = 1'b1;
    tick();
    in_en_funcion_rtc = 1'b0;
    while (k != L + TS + 3) tick();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("rst_cs_n", 8'(out_bus_cs_n), 8'd1);
    check_eq("rst_wr_n", 8'(out_bus_wr_n), 8'd1);
    check_eq("rst_oe", 8'(out_bus_oe), 8'd0);
    check_eq("rst_busy", 8'(out_ocupado), 8'd0);
    repeat (2) tick();
    reset = 1'b1;
    do_txn(1'b1, 8'h45, 1'b0, 8'h00, 8'h88);

    // randomized transactions with inputs scrambled while busy
    for (int t = 0; t < 15; t++) begin
      pad_val = 8'($urandom);
      scramble = 1'b1;
      do_txn(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      scramble = 1'b0;
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/rtc_bus_transaction_ctrl.md
Name: rtc_bus_transaction_ctrl

Overview:
- Executes one multiplexed address/data bus transaction (read or write) on the external RTC chip for each request from the RTC sequencing FSM.
- Generates chip select, address/data strobe, write/read strobes and tri-state data bus timing from cycle counters.
- Returns a one-cycle done flag, which advances the sequencer's access counter, plus the read data tagged with its register address.
- Sits between the RTC sequencing FSM (address, write/read, enable, init flag/data) and the top-level RTC pads.

Parameters:
T_SETUP, 2, cycles of setup before each strobe pulse (1..255)
T_PULSE, 8, cycles each WR/RD strobe is held low (1..255)
T_HOLD, 2, cycles of hold after each strobe pulse (1..255)
T_REC, 4, recovery cycles with CS deasserted before done (1..255)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
in_en_funcion_rtc  in  1  transaction request (level)
in_funcion_w_r  in  1  1=write, 0=read
in_addr_ram_rtc  in  8  RTC register address
in_flag_inicio  in  1  1=write data taken from in_dato_inicio, 0=from in_dato_config
in_dato_inicio  in  8  init write data
in_dato_config  in  8  user/config write data
in_bus_dato  in  8  data bus input from pad
out_bus_dato  out  8  data bus output to pad
out_bus_oe  out  1  pad output enable
out_bus_cs_n  out  1  chip select, active low
out_bus_ad  out  1  1=address phase, 0=data phase
out_bus_wr_n  out  1  write strobe, active low
out_bus_rd_n  out  1  read strobe, active low
out_flag_done  out  1  one-cycle pulse, transaction complete
out_dato_leido  out  8  last read data
out_addr_leido  out  8  address of last read data
out_dato_valido  out  1  one-cycle pulse with read completion
out_ocupado  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0; out_bus_cs_n/wr_n/rd_n/ad=1; out_bus_oe=0; out_bus_dato, out_dato_leido, out_addr_leido=0x00; out_flag_done, out_dato_valido, out_ocupado=0. Reset mid-transaction aborts immediately, bus released, no done pulse.
- States: IDLE -> ADDR_SETUP(T_SETUP) -> ADDR_PULSE(T_PULSE) -> ADDR_HOLD(T_HOLD) -> DATA_SETUP(T_SETUP) -> DATA_PULSE(T_PULSE) -> DATA_HOLD(T_HOLD) -> RECOVER(T_REC) -> DONE(1) -> IDLE. 8-bit counter cleared on every state entry; state exits when counter == N-1.
- Start: in IDLE with in_en_funcion_rtc=1, latch w_r, address and write data (mux on in_flag_inicio) that cycle; enter ADDR_SETUP next cycle. Latched values are held for the whole transaction; input changes are ignored.
- in_en_funcion_rtc dropping mid-transaction is ignored; the transaction completes.
- No restart from DONE. IDLE always takes one cycle, so the sequencer's updated address is sampled, not the stale one.
- Latency: first ADDR_SETUP cycle = 1; out_flag_done high at cycle 2*(T_SETUP+T_PULSE+T_HOLD)+T_REC+1 (29 with defaults). Back-to-back requests: next ADDR_SETUP 2 cycles after DONE.
- cs_n=0 from ADDR_SETUP through DATA_HOLD; 1 in RECOVER/DONE/IDLE.
- ad=1 in ADDR_*; 0 in DATA_*; 1 otherwise.
- wr_n=0 in ADDR_PULSE, and in DATA_PULSE if write. rd_n=0 in DATA_PULSE if read.
- oe=1 in ADDR_*, and in DATA_* if write; else 0.
- out_bus_dato = latched addr in ADDR_*; latched data in DATA_* if write; else 0x00.
- Read: in_bus_dato registered on the last DATA_PULSE cycle. In DONE: out_dato_leido/out_addr_leido update, out_dato_valido=1. Writes leave both registers unchanged, no valid pulse.
- All outputs registered or decoded from state only; no combinational path from inputs to outputs.

Test Plan:
- Reset released, en=0 for 50 cycles -> IDLE; cs_n=wr_n=rd_n=ad=1, oe=0, no done pulse.
- Write addr 0x21, flag_inicio=0, dato_config=0x45, defaults -> wr_n low 8 cycles with bus=0x21 ad=1, then 8 cycles with bus=0x45 ad=0; done at cycle 29; no valid pulse.
- Write with flag_inicio=1, dato_inicio=0xD2, dato_config=0x00, addr 0x10 -> data phase drives 0xD2.
- Read addr 0xF0, pad returns 0x5A only on last DATA_PULSE cycle -> oe=0 in data phase, rd_n low 8 cycles; out_dato_leido=0x5A, out_addr_leido=0xF0, valid and done together.
- en held high, sequencer increments addr on done (0x21->0x22) -> second transaction uses 0x22; ADDR_SETUP 2 cycles after DONE.
- reset asserted in DATA_PULSE of a write -> cs_n/wr_n=1 and oe=0 immediately; no done; next request runs full-length.
